// File: rtl/data_mem_responder.sv
// Byte-addressable 1 KB data memory with a fixed-latency busywait handshake.
// Supports RV32I load/store sizes and flags misaligned or illegal accesses.
module data_mem_responder #(
  parameter int LATENCY     = 3,
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] data_in,
  input  logic [2:0]  func3,
  output logic        busywait,
  output logic [31:0] data_out,
  output logic        mem_error
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic [9:0]  addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  func3_q;
  logic        write_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic             req;
  logic             start;
  logic             do_access;
  logic [IDX_W-1:0] idx;
  logic             misaligned;
  logic             illegal;
  logic             err;
  logic [31:0]      rword;
  logic [31:0]      rshift;
  logic [31:0]      rd_ext;
  logic [3:0]       be;
  logic [31:0]      wword;

  assign req       = mem_read | mem_write;
  assign start     = (state == IDLE) && req;
  assign do_access = (state == BUSY) && (cnt == 4'd0);
  assign idx       = addr_q[IDX_W+1:2];

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every output of this block is assigned a default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    next_state = state;
    busywait   = 1'b0;
    if (reset) begin
      unique case (state)
        IDLE: begin
          busywait = req;
          if (req) next_state = BUSY;
        end
        BUSY: begin
          busywait = 1'b1;
          if (cnt == 4'd0) next_state = DONE;
        end
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  assign mem_error = reset && (state == DONE) && err_q;

  // Access decode works on the latched request so the inputs may change once busywait drops.
  always_comb begin
    misaligned = ((func3_q[1:0] == 2'b01) && addr_q[0]) ||
                 ((func3_q == 3'b010) && (addr_q[1:0] != 2'b00));
    if (write_q) illegal = !(func3_q inside {3'b000, 3'b001, 3'b010});
    else         illegal = func3_q inside {3'b011, 3'b110, 3'b111};
    err = misaligned | illegal;
  end

  always_comb begin
    rword  = mem[idx];
    rshift = rword >> {addr_q[1:0], 3'b000};
    rd_ext = 32'd0;
    case (func3_q)
      3'b000:  rd_ext = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  rd_ext = {{16{rshift[15]}}, rshift[15:0]};
      3'b010:  rd_ext = rword;
      3'b100:  rd_ext = {24'd0, rshift[7:0]};
      3'b101:  rd_ext = {16'd0, rshift[15:0]};
      default: rd_ext = 32'd0;
    endcase
    if (err) rd_ext = 32'd0;
  end

  // Store data is replicated across lanes; the byte enables pick the addressed lanes.
  always_comb begin
    be    = 4'b0000;
    wword = wdata_q;
    case (func3_q)
      3'b000: begin
        be    = 4'b0001 << addr_q[1:0];
        wword = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        be    = 4'b0011 << {addr_q[1], 1'b0};
        wword = {2{wdata_q[15:0]}};
      end
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    if (err) be = 4'b0000;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= 4'd0;
      addr_q   <= 10'd0;
      wdata_q  <= 32'd0;
      func3_q  <= 3'd0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      data_out <= 32'd0;
    end else begin
      if (start) begin
        addr_q  <= mem_address[9:0];
        wdata_q <= data_in;
        func3_q <= func3;
        write_q <= mem_write;
        cnt     <= 4'(LATENCY - 1);
      end else if ((state == BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (do_access) begin
        err_q <= err;
        if (!write_q) data_out <= rd_ext;
      end
    end
  end

  // NOTE: the storage array is cleared by reset, so it is built from resettable flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int w = 0; w < DEPTH_WORDS; w++) mem[w] <= 32'd0;
    end else if (do_access && write_q) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (LATENCY=3 main instance,
// LATENCY=1 instance for the back-to-back handshake).
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, data_in;
  logic [2:0]  func3;
  logic        busywait, mem_error;
  logic [31:0] data_out;
  logic        busy1, err1;
  logic [31:0] dout1;

  int          checks = 0;
  int          errors = 0;
  int          last_busy;
  logic        last_err;
  logic [31:0] last_dout;

  always #5 clk = ~clk;

  data_mem_responder #(.LATENCY(3), .DEPTH_WORDS(256)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .data_in(data_in), .func3(func3),
    .busywait(busywait), .data_out(data_out), .mem_error(mem_error)
  );

  data_mem_responder #(.LATENCY(1), .DEPTH_WORDS(256)) dut1 (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .data_in(data_in), .func3(func3),
    .busywait(busy1), .data_out(dout1), .mem_error(err1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request on the main instance, count busywait cycles, capture DONE outputs.
  task automatic op(input logic rd, input logic wr, input logic [31:0] a,
                    input logic [31:0] d, input logic [2:0] f);
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_address = a; data_in = d; func3 = f;
    #1;
    last_busy = 0;
    while (busywait === 1'b1 && last_busy < 40) begin
      last_busy++;
      @(negedge clk);
    end
    last_err  = mem_error;
    last_dout = data_out;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    reset = 1'b0; mem_read = 1'b1; mem_write = 1'b0;
    mem_address = 32'd0; data_in = 32'd0; func3 = 3'b010;
    repeat (2) @(negedge clk);
    check("reset_busywait", {31'd0, busywait}, 32'd0);
    check("reset_mem_error", {31'd0, mem_error}, 32'd0);
    check("reset_data_out", data_out, 32'd0);
    mem_read = 1'b0;
    reset = 1'b1;

    op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
    check("sw_busy_cycles", last_busy, 32'd4);
    check("sw_mem_error", {31'd0, last_err}, 32'd0);
    op(1'b1, 1'b0, 32'h10, 32'd0, 3'b010);
    check("lw_busy_cycles", last_busy, 32'd4);
    check("lw_data", last_dout, 32'hDEADBEEF);
    check("lw_mem_error", {31'd0, last_err}, 32'd0);

    op(1'b0, 1'b1, 32'h13, 32'h00000080, 3'b000);
    op(1'b1, 1'b0, 32'h13, 32'd0, 3'b000);
    check("lb_sign", last_dout, 32'hFFFFFF80);
    op(1'b1, 1'b0, 32'h13, 32'd0, 3'b100);
    check("lbu_zero", last_dout, 32'h00000080);
    op(1'b1, 1'b0, 32'h10, 32'd0, 3'b010);
    check("lw_after_sb", last_dout, 32'h80ADBEEF);

    op(1'b0, 1'b1, 32'h21, 32'h00001234, 3'b001);
    check("sh_misaligned_err", {31'd0, last_err}, 32'd1);
    check("sh_misaligned_busy", last_busy, 32'd4);
    op(1'b1, 1'b0, 32'h20, 32'd0, 3'b010);
    check("lw_no_write", last_dout, 32'h00000000);
    check("lw_clean_err", {31'd0, last_err}, 32'd0);
    op(1'b0, 1'b1, 32'h22, 32'h0000F00D, 3'b001);
    check("sh_aligned_err", {31'd0, last_err}, 32'd0);
    check("data_out_held", last_dout, 32'h00000000);
    op(1'b1, 1'b0, 32'h22, 32'd0, 3'b001);
    check("lh_sign", last_dout, 32'hFFFFF00D);
    op(1'b1, 1'b0, 32'h22, 32'd0, 3'b101);
    check("lhu_zero", last_dout, 32'h0000F00D);

    op(1'b1, 1'b0, 32'h11, 32'd0, 3'b010);
    check("lw_misaligned_err", {31'd0, last_err}, 32'd1);
    check("lw_misaligned_data", last_dout, 32'd0);
    op(1'b1, 1'b0, 32'h10, 32'd0, 3'b011);
    check("ld_illegal_err", {31'd0, last_err}, 32'd1);
    check("ld_illegal_data", last_dout, 32'd0);
    op(1'b0, 1'b1, 32'h10, 32'h11111111, 3'b100);
    check("st_illegal_err", {31'd0, last_err}, 32'd1);
    op(1'b1, 1'b0, 32'h10, 32'd0, 3'b010);
    check("st_illegal_no_write", last_dout, 32'h80ADBEEF);

    op(1'b1, 1'b1, 32'h40, 32'h00000055, 3'b010);
    check("rw_both_busy", last_busy, 32'd4);
    check("rw_both_no_read", last_dout, 32'h80ADBEEF);
    op(1'b1, 1'b0, 32'h40, 32'd0, 3'b010);
    check("lw_after_rw", last_dout, 32'h00000055);
    op(1'b1, 1'b0, 32'h440, 32'd0, 3'b010);
    check("alias_1k", last_dout, 32'h00000055);

    // Reset pulsed in the 2nd BUSY cycle of a store.
    @(negedge clk);
    mem_write = 1'b1; mem_address = 32'h8; data_in = 32'hAA; func3 = 3'b010;
    repeat (2) @(negedge clk);
    check("busy_before_abort", {31'd0, busywait}, 32'd1);
    reset = 1'b0;
    #1;
    check("busy_gated_in_reset", {31'd0, busywait}, 32'd0);
    @(negedge clk);
    reset = 1'b1; mem_write = 1'b0;
    #1;
    check("busy_after_abort", {31'd0, busywait}, 32'd0);
    check("data_out_after_abort", data_out, 32'd0);
    op(1'b1, 1'b0, 32'h8, 32'd0, 3'b010);
    check("abort_no_write", last_dout, 32'd0);
    check("post_reset_busy", last_busy, 32'd4);

    // Back-to-back loads on the LATENCY=1 instance with the request held.
    op(1'b0, 1'b1, 32'h30, 32'h5A5A5A5A, 3'b010);
    repeat (6) @(negedge clk);
    mem_read = 1'b1; mem_address = 32'h30; func3 = 3'b010;
    #1;
    check("b2b_c1", {31'd0, busy1}, 32'd1);
    @(negedge clk);
    check("b2b_c2", {31'd0, busy1}, 32'd1);
    @(negedge clk);
    check("b2b_c3", {31'd0, busy1}, 32'd0);
    check("b2b_data", dout1, 32'h5A5A5A5A);
    @(negedge clk);
    check("b2b_c4", {31'd0, busy1}, 32'd1);
    @(negedge clk);
    check("b2b_c5", {31'd0, busy1}, 32'd1);
    @(negedge clk);
    check("b2b_c6", {31'd0, busy1}, 32'd0);
    mem_read = 1'b0;
    @(negedge clk);
    check("b2b_no_requeue", {31'd0, busy1}, 32'd0);

    repeat (8) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter LATENCY, default 3, SHALL set access wait cycles; legal range 1..15.
REQ-002 Parameter DEPTH_WORDS, default 256, SHALL set storage depth in 32-bit words (1 KB byte-addressable).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-low reset.
REQ-005 mem_read  input  1  SHALL be the load request, held by the requester while busywait=1.
REQ-006 mem_write  input  1  SHALL be the store request, held by the requester while busywait=1.
REQ-007 mem_address  input  32  SHALL be the byte address; only bits [9:0] are used.
REQ-008 data_in  input  32  SHALL be the store data, right-aligned.
REQ-009 func3  input  3  SHALL select the access size and sign mode per RV32I load/store encoding.
REQ-010 busywait  output  1  SHALL stall the requester while high.
REQ-011 data_out  output  32  SHALL be the registered, extended load result.
REQ-012 mem_error  output  1  SHALL flag a misaligned or illegal access for one cycle.

Function
REQ-013 The FSM SHALL have the states IDLE, BUSY and DONE.
REQ-014 IDLE: busywait SHALL equal (mem_read|mem_write) combinationally; on a request, at the edge the block SHALL latch address, data_in, func3 and op, load cnt=LATENCY-1, and move to BUSY.
REQ-015 BUSY: busywait=1; if cnt!=0 the block SHALL decrement cnt, otherwise it SHALL perform the access at that edge and move to DONE.
REQ-016 DONE: busywait=0; requests SHALL be ignored (they belong to the completed op); the next edge SHALL go to IDLE.
REQ-017 Latency: busywait SHALL be high for exactly LATENCY+1 consecutive cycles per request; data_out SHALL be valid from the first cycle of DONE.
REQ-018 If mem_read and mem_write are both high, write SHALL take priority and no read result SHALL be produced.
REQ-019 Byte order SHALL be little-endian; the word index SHALL be addr[9:2]; higher address bits SHALL be ignored, so addresses wrap modulo 1 KB.
REQ-020 Loads: 000 LB sign-extends the byte; 001 LH sign-extends the half; 010 LW; 100 LBU and 101 LHU zero-extend.
REQ-021 Stores: 000 SB writes data_in[7:0]; 001 SH writes data_in[15:0]; 010 SW writes all 32 bits; unaddressed bytes SHALL remain unchanged.
REQ-022 Misalignment is a half access with addr[0]=1, or a word access with addr[1:0]!=0; such an access SHALL NOT modify memory.
REQ-023 A read that is misaligned or has an illegal func3 (011, 110, 111; 100/101 on a store) SHALL return data_out=0.
REQ-024 mem_error SHALL be high only in the DONE cycle of a misaligned or illegal access; the handshake timing SHALL be unchanged.
REQ-025 data_out SHALL hold its value through writes and idle cycles until the next read completes.
REQ-026 Requests that fall during DONE SHALL NOT be queued.

Reset
REQ-027 When reset=0 at an edge, the block SHALL enter IDLE, set cnt=0 and data_out=0, and clear all memory words to 0.
REQ-028 While reset=0, busywait and mem_error SHALL be 0, regardless of the request inputs.
REQ-029 Reset asserted mid-BUSY SHALL abort the access with no memory write.
REQ-030 After reset deasserts, the first request SHALL be serviced normally.

Verification
REQ-031 SW 0xDEADBEEF @0x10, then LW @0x10, LATENCY=3 -> busywait high for 4 cycles on each; data_out=0xDEADBEEF in DONE; mem_error=0.
REQ-032 SB 0x80 @0x13, then LB @0x13 and LBU @0x13 -> data_out=0xFFFFFF80, then 0x00000080; LW @0x10 -> 0x80ADBEEF.
REQ-033 SH 0x1234 @0x21 -> mem_error=1 in DONE; LW @0x20 -> 0x00000000; LH @0x22 after SH 0xF00D @0x22 -> 0xFFFFF00D.
REQ-034 mem_read=mem_write=1, SW 0x55 @0x40 -> store performed; LW @0x40 -> 0x00000055; address 0x440 aliases to 0x40.
REQ-035 Reset pulsed at the 2nd BUSY cycle of SW 0xAA @0x8 -> busywait=0 next cycle; LW @0x8 -> 0x00000000.
REQ-036 LATENCY=1 back-to-back LW requests -> busywait pattern 1,1,0,1,1,0; request held during DONE not double-serviced.
